// File: rtl/product_replace_reg_if.sv
// Bundle of the update and snapshot handshakes for product_replace_reg.
//
// Signals:
//   upd_valid  : update request valid (producer -> register)
//   upd_ready  : update accepted when upd_valid & upd_ready (register -> producer)
//   upd_mask   : per-field replace enable, NFIELDS bits
//   upd_data   : replacement field values, NFIELDS*WIDTH bits
//   snap_valid : snapshot available (register -> consumer)
//   snap_ready : consumer accepts the head snapshot
//   snap_data  : oldest queued snapshot, NFIELDS*WIDTH bits
//
// Modports: master = producer/consumer side, slave = the register itself.
interface product_replace_reg_if #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned NFIELDS = 2
);
  logic                     upd_valid;
  logic                     upd_ready;
  logic [NFIELDS-1:0]       upd_mask;
  logic [NFIELDS*WIDTH-1:0] upd_data;
  logic                     snap_valid;
  logic                     snap_ready;
  logic [NFIELDS*WIDTH-1:0] snap_data;

  modport master (
    output upd_valid, upd_mask, upd_data, snap_ready,
    input  upd_ready, snap_valid, snap_data
  );

  modport slave (
    input  upd_valid, upd_mask, upd_data, snap_ready,
    output upd_ready, snap_valid, snap_data
  );
endinterface

// File: rtl/product_replace_reg.sv
// Product-type state register of NFIELDS fields, WIDTH bits each, with
// masked field replacement and an ordered FIFO of post-update snapshots.
//
// Ports:
//   CLK       : clock, all state changes on the rising edge
//   RESET     : synchronous active-high reset (state := INIT, FIFO emptied)
//   bus       : product_replace_reg_if.slave (update and snapshot handshakes)
//   O         : live state, straight from the state register
//   upd_count : accepted-update counter, wraps modulo 2^CNT_WIDTH
//               (present only when PRODUCT_REPLACE_COUNT_EN is defined)
//
// Optional feature macro: PRODUCT_REPLACE_COUNT_EN
module product_replace_reg #(
  parameter int unsigned              WIDTH      = 1,
  parameter int unsigned              NFIELDS    = 2,
  parameter logic [NFIELDS*WIDTH-1:0] INIT       = '1,
  parameter int unsigned              SNAP_DEPTH = 2,
  parameter int unsigned              CNT_WIDTH  = 16
) (
  input  logic                      CLK,
  input  logic                      RESET,
  product_replace_reg_if.slave      bus,
  output logic [NFIELDS*WIDTH-1:0]  O
`ifdef PRODUCT_REPLACE_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0]      upd_count
`endif
);

  localparam int unsigned DW = NFIELDS * WIDTH;
  localparam int unsigned PW = $clog2(SNAP_DEPTH);
  localparam int unsigned CW = PW + 1;

  // Depth must be a power of two so the pointers wrap naturally.
  if ((SNAP_DEPTH < 2) || ((SNAP_DEPTH & (SNAP_DEPTH - 1)) != 0) ||
      (CNT_WIDTH == 0)) begin : g_bad_cfg
    $error("product_replace_reg: SNAP_DEPTH must be a power of two >= 2 and CNT_WIDTH > 0");
  end

  logic [DW-1:0] state_q, state_d;
  logic [DW-1:0] mem_q [SNAP_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          accept;
  logic          pop;

  // Ready depends only on registered occupancy and RESET, never on snap_ready.
  always_comb begin
    bus.upd_ready  = !RESET && (count_q < CW'(SNAP_DEPTH));
    bus.snap_valid = (count_q != '0);
    bus.snap_data  = mem_q[rd_ptr_q];
    accept         = bus.upd_valid && bus.upd_ready;
    pop            = bus.snap_valid && bus.snap_ready;
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      for (int unsigned i = 0; i < NFIELDS; i++) begin
        if (bus.upd_mask[i]) begin
          state_d[i*WIDTH +: WIDTH] = bus.upd_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= INIT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Snapshot storage needs no reset: occupancy alone qualifies the contents.
  // The pushed value is state_d so the entry equals S after this same edge.
  always_ff @(posedge CLK) begin
    if (accept) mem_q[wr_ptr_q] <= state_d;
  end

  assign O = state_q;

`ifdef PRODUCT_REPLACE_COUNT_EN
  logic [CNT_WIDTH-1:0] upd_count_q;

  always_ff @(posedge CLK) begin
    if (RESET)       upd_count_q <= '0;
    else if (accept) upd_count_q <= upd_count_q + CNT_WIDTH'(1);
  end

  assign upd_count = upd_count_q;
`endif

endmodule

// File: tb/tb_product_replace_reg.sv
// Directed bench for product_replace_reg (WIDTH=4, NFIELDS=2, INIT=8'h11,
// SNAP_DEPTH=2, CNT_WIDTH=4) with a reference model and snapshot queue.
module tb_product_replace_reg;
  localparam int unsigned W = 4;
  localparam int unsigned N = 2;
  localparam int          D = 2;
  localparam logic [7:0]  INIT_V = 8'h11;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] O;
`ifdef PRODUCT_REPLACE_COUNT_EN
  logic [3:0] upd_count;
`endif

  product_replace_reg_if #(.WIDTH(W), .NFIELDS(N)) bus ();

  product_replace_reg #(
    .WIDTH(W), .NFIELDS(N), .INIT(INIT_V), .SNAP_DEPTH(D), .CNT_WIDTH(4)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus),
    .O(O)
`ifdef PRODUCT_REPLACE_COUNT_EN
    ,
    .upd_count(upd_count)
`endif
  );

  always #5 CLK = ~CLK;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_s;
  logic [3:0] model_cnt;
  logic       last_acc;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered #1 after a rising edge with inputs already driven; checks the
  // DUT against the model, then advances one clock and updates the model.
  task automatic cyc();
    logic       exp_ready, exp_valid, do_pop, do_acc;
    logic [7:0] nxt;
    #1;
    exp_ready = !RESET && (exp_q.size() < D);
    exp_valid = (exp_q.size() != 0);
    chk("upd_ready", 8'(bus.upd_ready), 8'(exp_ready));
    chk("snap_valid", 8'(bus.snap_valid), 8'(exp_valid));
    chk("O", O, model_s);
`ifdef PRODUCT_REPLACE_COUNT_EN
    chk("upd_count", 8'(upd_count), 8'(model_cnt));
`endif
    do_pop = exp_valid && bus.snap_ready;
    if (do_pop) chk("snap_data", bus.snap_data, exp_q[0]);
    do_acc = bus.upd_valid && exp_ready;
    nxt = model_s;
    for (int i = 0; i < int'(N); i++)
      if (bus.upd_mask[i]) nxt[i*W +: W] = bus.upd_data[i*W +: W];
    @(posedge CLK); #1;
    last_acc = do_acc;
    if (RESET) begin
      model_s = INIT_V;
      exp_q.delete();
      model_cnt = '0;
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_acc) begin
        exp_q.push_back(nxt);
        model_s = nxt;
        model_cnt = model_cnt + 4'd1;
      end
    end
  endtask

  task automatic offer(input logic [1:0] m, input logic [7:0] d, input int budget);
    bus.upd_valid = 1'b1;
    bus.upd_mask  = m;
    bus.upd_data  = d;
    last_acc = 1'b0;
    for (int k = 0; k < budget; k++) begin
      cyc();
      if (last_acc) break;
    end
    if (!last_acc) begin
      miscompares++;
      $error("FAIL offer_timeout: observed no accept expected accept of %h", d);
    end
    bus.upd_valid = 1'b0;
  endtask

  initial begin
    RESET          = 1'b1;
    bus.upd_valid  = 1'b0;
    bus.upd_mask   = '0;
    bus.upd_data   = '0;
    bus.snap_ready = 1'b0;
    model_cnt      = '0;
    last_acc       = 1'b0;
    @(posedge CLK); #1;
    model_s = INIT_V;
    exp_q.delete();

    // Reset: second reset cycle, then release
    cyc();
    RESET = 1'b0;
    cyc();

    // Partial replace
    bus.snap_ready = 1'b1;
    offer(2'b01, 8'hAB, 4);
    chk("partial_lo", O, 8'h1B);
    offer(2'b10, 8'hC0, 4);
    chk("partial_hi", O, 8'hCB);
    cyc();
    cyc();

    // Backpressure
    bus.snap_ready = 1'b0;
    offer(2'b11, 8'h01, 4);
    offer(2'b11, 8'h02, 4);
    bus.upd_valid = 1'b1;
    bus.upd_data  = 8'h03;
    cyc();
    cyc();
    bus.snap_ready = 1'b1;
    cyc();                 // pops 01, FIFO still full at sample
    offer(2'b11, 8'h03, 4); // accepted the cycle after the first pop
    cyc();
    cyc();

    // Simultaneous push/pop, then zero-mask update
    bus.snap_ready = 1'b0;
    offer(2'b11, 8'hAA, 4);
    bus.snap_ready = 1'b1;
    offer(2'b11, 8'h55, 4);
    offer(2'b00, 8'hFF, 4);
    chk("zero_mask_O", O, 8'h55);
    cyc();
    cyc();

    // Reset mid-operation with a full FIFO and an update on offer
    bus.snap_ready = 1'b0;
    offer(2'b01, 8'h0B, 4);
    offer(2'b10, 8'hC0, 4);
    chk("full_O", O, 8'hCB);
    bus.upd_valid = 1'b1;
    bus.upd_mask  = 2'b11;
    bus.upd_data  = 8'h77;
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    bus.upd_valid = 1'b0;
    cyc();
    chk("post_reset_O", O, INIT_V);
    cyc();

`ifdef PRODUCT_REPLACE_COUNT_EN
    // Counter wrap and clear
    bus.snap_ready = 1'b1;
    for (int k = 0; k < 17; k++) offer(2'b11, 8'(k), 4);
    chk("count_wrap", 8'(upd_count), 8'h01);
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    cyc();
    chk("count_clear", 8'(upd_count), 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/product_replace_reg.md
# product_replace_reg

Parametrised product-type state register with field-granular replace updates and a buffered snapshot stream. It generalises the fixed two-field constant product output to NFIELDS fields of WIDTH bits with a programmable reset value. Each accepted update replaces a masked subset of fields, and the resulting whole-product value is queued to a downstream consumer. It sits between a control-side producer and any logic that needs both a live product value and an ordered log of its updates.

## Interface
- WIDTH, 1: bits per field.
- NFIELDS, 2: number of fields; field i occupies bits [i*WIDTH +: WIDTH] (field 0 = x, field 1 = y).
- INIT, all ones: NFIELDS*WIDTH reset value of the state.
- SNAP_DEPTH, 2: snapshot FIFO entries; power of two, at least 2.
- CNT_WIDTH, 16: update counter width (used only with the macro).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- upd_valid  input  1  update request valid.
- upd_ready  output  1  update accepted when upd_valid & upd_ready.
- upd_mask  input  NFIELDS  per-field replace enable.
- upd_data  input  NFIELDS*WIDTH  replacement field values.
- O  output  NFIELDS*WIDTH  live state, driven directly from the state register.
- snap_valid  output  1  snapshot available.
- snap_ready  input  1  consumer accepts the snapshot.
- snap_data  output  NFIELDS*WIDTH  oldest queued snapshot.
- upd_count  output  CNT_WIDTH  accepted-update count; present only with PRODUCT_REPLACE_COUNT_EN.

## Operation
- State S holds NFIELDS fields.
- On an accepted update, the next value of field i is upd_data field i when upd_mask[i] is set, else S field i.
- An accept with an all-zero mask is legal: it leaves S unchanged and still pushes a snapshot.
- On every accept, the post-update S value is pushed into the snapshot FIFO on the same edge that writes S.
- FIFO behaviour:
  - Order is FIFO.
  - snap_data shows the head entry.
  - A pop occurs on snap_valid & snap_ready.
  - An entry's content is never altered by later updates.
- upd_ready = !RESET & (count < SNAP_DEPTH), where count is the registered FIFO occupancy. There is no combinational path from snap_ready to upd_ready.
- Push and pop in the same cycle: count is unchanged and ordering is preserved.
- upd_data and upd_mask are ignored when no accept occurs.

## Timing
- Reset, applied synchronously while RESET is high:
  - S = INIT, so O = INIT from the edge after RESET is sampled.
  - FIFO is emptied; snap_valid = 0.
  - upd_count = 0.
  - upd_ready = 0 while RESET is high, and 1 in the first cycle after release.
- Reset mid-operation discards queued snapshots and any update offered in the same cycle.
- Update latency: accept in cycle n gives O = new value in cycle n+1, and snap_valid = 1 in cycle n+1 if the FIFO was previously empty.
- Full FIFO (count = SNAP_DEPTH):
  - upd_ready is low and the producer must hold its request.
  - A pop in cycle n raises upd_ready in cycle n+1.
- Empty FIFO: snap_valid = 0 and snap_data is don't-care. A pop is never performed.
- Sustained throughput is one update per cycle when snap_ready is held high.

## Configuration
- PRODUCT_REPLACE_COUNT_EN defined:
  - The upd_count port exists.
  - The counter increments by 1 on each accepted update and wraps modulo 2^CNT_WIDTH.
  - The counter is cleared by RESET.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=4, NFIELDS=2, INIT=8'h11, SNAP_DEPTH=2.
- Reset: RESET high for 2 cycles, then low -> O=8'h11, snap_valid=0; upd_ready=0 during reset and 1 on the first cycle after release.
- Partial replace: upd_mask=2'b01, upd_data=8'hAB -> next cycle O=8'h1B, snap_valid=1, snap_data=8'h1B. Then mask 2'b10, data 8'hC0 -> O=8'hCB.
- Backpressure: snap_ready=0, offer updates (mask 2'b11) with data 8'h01, 8'h02, 8'h03:
  - Two accepts, then upd_ready=0 and 8'h03 is held.
  - Raise snap_ready -> pops 8'h01 then 8'h02; 8'h03 is accepted the cycle after the first pop and popped last.
- Simultaneous push/pop: at count=1, accept an update while popping -> count stays 1 and order is preserved. Zero-mask update -> O unchanged and a snapshot equal to O is pushed.
- Reset mid-operation: FIFO full and O=8'hCB, assert RESET for 1 cycle -> O=8'h11, snap_valid=0, upd_ready=1 after release.
- Counter (macro defined, CNT_WIDTH=4): 17 accepted updates -> upd_count=1 (wrapped). Assert RESET -> 0.
